// File: rtl/color_gamma_pipeline.sv
// Four-stage pixel post-processing pipeline: colour/range conversion (A/B), quadratic curve (C),
// lane mapper (D). RAM write sidebands ride alongside with identical 4-clock latency.
module color_gamma_pipeline #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            color_config,
    input  logic [4:0]            gamma_config,
    input  logic [23:0]           mapperconf,
    input  logic                  in_wren,
    input  logic [ADDR_WIDTH-1:0] in_wraddr,
    input  logic [7:0]            in_red,
    input  logic [7:0]            in_green,
    input  logic [7:0]            in_blue,
    input  logic                  in_starttrigger,
    output logic                  wren,
    output logic [ADDR_WIDTH-1:0] wraddr,
    output logic [23:0]           wrdata,
    output logic                  starttrigger
);

    function automatic logic [7:0] sat8(input logic signed [19:0] v);
        if (v < 20'sd0)
            return 8'd0;
        else if (v > 20'sd255)
            return 8'd255;
        return v[7:0];
    endfunction

    function automatic logic [7:0] limit8(input logic [7:0] c);
        logic [15:0] p;
        p = {8'd0, c} * 16'd220;
        return 8'(p >> 8) + 8'd16;
    endfunction

    // c*(255-c) peaks at 16256, so t never exceeds 63 and c+t / c-t stay inside 0..255
    function automatic logic [7:0] curve8(input logic [7:0] c, input logic [3:0] g);
        logic [17:0] prod;
        logic [7:0]  t;
        prod = ({15'd0, g[2:0]} + 18'd1) * {10'd0, c} * {10'd0, 8'd255 - c};
        t    = 8'(prod >> 11);
        return g[3] ? (c - t) : (c + t);
    endfunction

    function automatic logic [7:0] map8(input logic [2:0] f, input logic [23:0] p);
        logic [7:0] l;
        case (f[1:0])
            2'd0:    l = p[23:16];
            2'd1:    l = p[15:8];
            2'd2:    l = p[7:0];
            default: l = 8'd0;
        endcase
        return f[2] ? ~l : l;
    endfunction

    logic unused_mapper_reserved;
    assign unused_mapper_reserved = ^{mapperconf[23:19], mapperconf[15:11], mapperconf[7:3]};

    logic signed [19:0] r_s, g_s, b_s;
    logic signed [19:0] y_n, cb_n, cr_n;

    assign r_s = signed'({12'd0, in_red});
    assign g_s = signed'({12'd0, in_green});
    assign b_s = signed'({12'd0, in_blue});

    // Grayscale and every non-709 mode reuse the BT.601 sums
    always_comb begin
        y_n  = 20'sd0;
        cb_n = 20'sd0;
        cr_n = 20'sd0;
        if (color_config == 3'd3) begin
            y_n  = 20'sd54 * r_s + 20'sd183 * g_s + 20'sd19 * b_s + 20'sd128;
            cb_n = 20'sd128 * b_s - 20'sd29 * r_s - 20'sd99 * g_s + 20'sd128;
            cr_n = 20'sd128 * r_s - 20'sd116 * g_s - 20'sd12 * b_s + 20'sd128;
        end else begin
            y_n  = 20'sd77 * r_s + 20'sd150 * g_s + 20'sd29 * b_s + 20'sd128;
            cb_n = 20'sd128 * b_s - 20'sd43 * r_s - 20'sd85 * g_s + 20'sd128;
            cr_n = 20'sd128 * r_s - 20'sd107 * g_s - 20'sd21 * b_s + 20'sd128;
        end
    end

    logic [2:0]            a_mode;
    logic [23:0]           a_pix;
    logic signed [19:0]    a_y, a_cb, a_cr;
    logic [23:0]           b_pix, c_pix;
    logic [23:0]           b_n, c_n, d_n;
    logic [7:0]            y8, cb8, cr8;
    logic [2:0]            wren_sr, trig_sr;
    logic [ADDR_WIDTH-1:0] addr_sr [3];

    assign y8  = sat8(a_y >>> 8);
    assign cb8 = sat8((a_cb >>> 8) + 20'sd128);
    assign cr8 = sat8((a_cr >>> 8) + 20'sd128);

    always_comb begin
        b_n = a_pix;
        case (a_mode)
            3'd1:       b_n = {limit8(a_pix[23:16]), limit8(a_pix[15:8]), limit8(a_pix[7:0])};
            3'd2, 3'd3: b_n = {cr8, y8, cb8};
            3'd4:       b_n = {y8, y8, y8};
            default:    b_n = a_pix;
        endcase
    end

    always_comb begin
        c_n = b_pix;
        if (gamma_config[4])
            c_n = {curve8(b_pix[23:16], gamma_config[3:0]),
                   curve8(b_pix[15:8],  gamma_config[3:0]),
                   curve8(b_pix[7:0],   gamma_config[3:0])};
    end

    assign d_n = {map8(mapperconf[18:16], c_pix),
                  map8(mapperconf[10:8],  c_pix),
                  map8(mapperconf[2:0],   c_pix)};

    always_ff @(posedge clock) begin
        if (reset) begin
            a_mode       <= '0;
            a_pix        <= '0;
            a_y          <= '0;
            a_cb         <= '0;
            a_cr         <= '0;
            b_pix        <= '0;
            c_pix        <= '0;
            wren_sr      <= '0;
            trig_sr      <= '0;
            addr_sr[0]   <= '0;
            addr_sr[1]   <= '0;
            addr_sr[2]   <= '0;
            wren         <= 1'b0;
            wraddr       <= '0;
            wrdata       <= '0;
            starttrigger <= 1'b0;
        end else begin
            a_mode       <= color_config;
            a_pix        <= {in_red, in_green, in_blue};
            a_y          <= y_n;
            a_cb         <= cb_n;
            a_cr         <= cr_n;
            b_pix        <= b_n;
            c_pix        <= c_n;
            wren_sr      <= {wren_sr[1:0], in_wren};
            trig_sr      <= {trig_sr[1:0], in_starttrigger};
            addr_sr[0]   <= in_wraddr;
            addr_sr[1]   <= addr_sr[0];
            addr_sr[2]   <= addr_sr[1];
            wren         <= wren_sr[2];
            wraddr       <= addr_sr[2];
            wrdata       <= d_n;
            starttrigger <= trig_sr[2];
        end
    end

endmodule

// File: tb/tb_color_gamma_pipeline.sv
// Scoreboard bench for color_gamma_pipeline: driver pushes expected outputs with their due cycle,
// a monitor pops and compares whenever wren or starttrigger is seen.
module tb_color_gamma_pipeline;

    localparam int AW = 15;
    localparam logic [23:0] MAP_ID = 24'h000102;

    logic          clock = 1'b0;
    logic          reset;
    logic [2:0]    color_config;
    logic [4:0]    gamma_config;
    logic [23:0]   mapperconf;
    logic          in_wren;
    logic [AW-1:0] in_wraddr;
    logic [7:0]    in_red, in_green, in_blue;
    logic          in_starttrigger;
    logic          wren;
    logic [AW-1:0] wraddr;
    logic [23:0]   wrdata;
    logic          starttrigger;

    color_gamma_pipeline #(.ADDR_WIDTH(AW)) dut (
        .clock(clock),
        .reset(reset),
        .color_config(color_config),
        .gamma_config(gamma_config),
        .mapperconf(mapperconf),
        .in_wren(in_wren),
        .in_wraddr(in_wraddr),
        .in_red(in_red),
        .in_green(in_green),
        .in_blue(in_blue),
        .in_starttrigger(in_starttrigger),
        .wren(wren),
        .wraddr(wraddr),
        .wrdata(wrdata),
        .starttrigger(starttrigger)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic          w;
        logic          t;
        logic [AW-1:0] a;
        logic [23:0]   d;
        int            c;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b, input logic t,
                         input logic [23:0] d);
        exp_t e;
        @(negedge clock);
        in_wren         = w;
        in_wraddr       = a;
        in_red          = r;
        in_green        = g;
        in_blue         = b;
        in_starttrigger = t;
        if (w || t) begin
            e.w = w;
            e.t = t;
            e.a = a;
            e.d = d;
            e.c = cyc + 4;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, '0, 8'd0, 8'd0, 8'd0, 1'b0, 24'd0);
    endtask

    task automatic set_cfg(input logic [2:0] cc, input logic [4:0] gc, input logic [23:0] mc);
        idle(5);
        color_config = cc;
        gamma_config = gc;
        mapperconf   = mc;
    endtask

    task automatic px(input logic [AW-1:0] a, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic [23:0] d);
        drive(1'b1, a, r, g, b, 1'b0, d);
    endtask

    // Monitor: every output event must match the oldest pending expectation, on its due cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (wren || starttrigger) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got wren=%0b trig=%0b addr=%h data=%h, expected no event",
                             wren, starttrigger, wraddr, wrdata);
                end else begin
                    e = q.pop_front();
                    chk("wren", 32'(wren), 32'(e.w));
                    chk("starttrigger", 32'(starttrigger), 32'(e.t));
                    chk("latency_cycle", 32'(cyc), 32'(e.c));
                    if (e.w) begin
                        chk("wraddr", 32'(wraddr), 32'(e.a));
                        chk("wrdata", 32'(wrdata), 32'(e.d));
                    end
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        color_config    = 3'd0;
        gamma_config    = 5'd0;
        mapperconf      = MAP_ID;
        in_wren         = 1'b0;
        in_wraddr       = '0;
        in_red          = 8'd0;
        in_green        = 8'd0;
        in_blue         = 8'd0;
        in_starttrigger = 1'b0;

        repeat (3) @(negedge clock);
        chk("reset_wren", 32'(wren), 32'd0);
        chk("reset_wraddr", 32'(wraddr), 32'd0);
        chk("reset_wrdata", 32'(wrdata), 32'd0);
        chk("reset_trig", 32'(starttrigger), 32'd0);
        reset = 1'b0;

        // Sidebands, trigger without wren, back-to-back with a one-cycle gap
        drive(1'b1, 15'h1234, 8'h12, 8'h34, 8'h56, 1'b1, 24'h123456);
        idle(6);
        drive(1'b0, 15'h0, 8'h00, 8'h00, 8'h00, 1'b1, 24'h0);
        idle(6);
        px(15'h0010, 8'hAA, 8'hBB, 8'hCC, 24'hAABBCC);
        idle(1);
        px(15'h0011, 8'h01, 8'h02, 8'h03, 24'h010203);
        px(15'h0012, 8'hFE, 8'h80, 8'h7F, 24'hFE807F);

        // Limited range: 128*220>>8 = 110, +16 = 126
        set_cfg(3'd1, 5'd0, MAP_ID);
        px(15'h0020, 8'd255, 8'd0, 8'd128, 24'hEB107E);
        px(15'h0021, 8'd0, 8'd255, 8'd255, 24'h10EBEB);

        set_cfg(3'd2, 5'd0, MAP_ID);
        px(15'h0030, 8'd255, 8'd255, 8'd255, 24'h80FF80);
        px(15'h0031, 8'd255, 8'd0, 8'd0, 24'hFF4D55);
        px(15'h0032, 8'd0, 8'd255, 8'd0, 24'h15952B);
        px(15'h0033, 8'd0, 8'd0, 8'd0, 24'h800080);

        set_cfg(3'd3, 5'd0, MAP_ID);
        px(15'h0040, 8'd255, 8'd255, 8'd255, 24'h80FF80);
        px(15'h0041, 8'd255, 8'd0, 8'd0, 24'hFF3663);
        px(15'h0042, 8'd0, 8'd0, 8'd255, 24'h7413FF);

        set_cfg(3'd4, 5'd0, MAP_ID);
        px(15'h0050, 8'd255, 8'd0, 8'd0, 24'h4D4D4D);
        px(15'h0051, 8'd10, 8'd20, 8'd30, 24'h121212);

        set_cfg(3'd5, 5'd0, MAP_ID);
        px(15'h0058, 8'h11, 8'h22, 8'h33, 24'h112233);

        // Curve: brighten/darken at s=7, fixed points, and s=0
        set_cfg(3'd0, 5'b10111, MAP_ID);
        px(15'h0060, 8'd128, 8'd128, 8'd128, 24'hBFBFBF);
        px(15'h0061, 8'd0, 8'd255, 8'd128, 24'h00FFBF);
        set_cfg(3'd0, 5'b11111, MAP_ID);
        px(15'h0062, 8'd128, 8'd128, 8'd128, 24'h414141);
        px(15'h0063, 8'd0, 8'd255, 8'd128, 24'h00FF41);
        set_cfg(3'd0, 5'b10000, MAP_ID);
        px(15'h0064, 8'd64, 8'd128, 8'd0, 24'h458700);

        // Mapper: red<-B, green<-~R, blue<-R; zero; all-invert; reserved bits ignored
        set_cfg(3'd0, 5'd0, 24'h020400);
        px(15'h0070, 8'h11, 8'h22, 8'h33, 24'h33EE11);
        set_cfg(3'd0, 5'd0, 24'h030303);
        px(15'h0071, 8'h11, 8'h22, 8'h33, 24'h000000);
        set_cfg(3'd0, 5'd0, 24'h040404);
        px(15'h0072, 8'h11, 8'h22, 8'h33, 24'hEEEEEE);
        set_cfg(3'd0, 5'd0, 24'hF9FAF8);
        px(15'h0073, 8'h11, 8'h22, 8'h33, 24'h223311);

        // Reset mid-stream flushes everything still in flight
        set_cfg(3'd0, 5'd0, MAP_ID);
        for (int i = 0; i < 4; i++)
            px(15'(15'h100 + i), 8'(i), 8'(i), 8'(i), {8'(i), 8'(i), 8'(i)});
        @(negedge clock);
        reset     = 1'b1;
        in_wren   = 1'b1;
        in_wraddr = 15'h01FF;
        q.delete();
        @(posedge clock);
        #1;
        chk("flush_wren", 32'(wren), 32'd0);
        chk("flush_wraddr", 32'(wraddr), 32'd0);
        chk("flush_wrdata", 32'(wrdata), 32'd0);
        chk("flush_trig", 32'(starttrigger), 32'd0);
        reset     = 1'b0;
        in_wren   = 1'b0;
        in_wraddr = '0;
        for (int i = 0; i < 3; i++)
            px(15'(15'h200 + i), 8'h40, 8'(i), 8'h80, {8'h40, 8'(i), 8'h80});
        idle(1);

        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(negedge clock);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
